// File: rtl/cluster_clock_gate_ctrl.sv
// Per-channel idle-driven clock gating controller with a latch-based gating cell per channel.
// Each channel counts idle cycles, gates its clock past a live threshold, and reports ready after a wake settle.

module cluster_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_l;

    // Enable is captured while the clock is low so the gated clock never glitches.
    always_latch begin
        if (!clk_i) en_l <= en_i | test_en_i;
    end

    assign clk_o = clk_i & en_l;

endmodule

module cluster_clock_gate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         test_en_i,
    input  logic [NUM_CH-1:0]            busy_i,
    input  logic [NUM_CH-1:0]            force_on_i,
    input  logic [IDLE_W-1:0]            idle_thresh_i,
    output logic [NUM_CH-1:0]            clk_o,
    output logic [NUM_CH-1:0]            clk_en_o,
    output logic [NUM_CH-1:0]            ready_o,
    output logic [$clog2(NUM_CH+1)-1:0]  n_gated_o
);

    localparam int unsigned CNT_W = $clog2(NUM_CH + 1);
    localparam logic [3:0]  WAKE_LAST = 4'(WAKE_CYC - 1);

    typedef enum logic [1:0] {RUN, COUNT, GATED, WAKE} state_e;

    state_e            state_q    [NUM_CH];
    logic [IDLE_W-1:0] idle_cnt_q [NUM_CH];
    logic [3:0]        wake_cnt_q [NUM_CH];
    logic [IDLE_W-1:0] thresh_m1_c;
    logic [CNT_W-1:0]  gated_cnt_c;

    assign thresh_m1_c = idle_thresh_i - IDLE_W'(1);

    always_comb begin
        gated_cnt_c = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            gated_cnt_c = gated_cnt_c + CNT_W'(state_q[n] == GATED);
        end
    end

    // Outputs only change on the transitions that alter them, so they track state exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < NUM_CH; n++) begin
                state_q[n]    <= RUN;
                idle_cnt_q[n] <= '0;
                wake_cnt_q[n] <= '0;
            end
            clk_en_o  <= '1;
            ready_o   <= '1;
            n_gated_o <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                unique case (state_q[n])
                    RUN: begin
                        if (!busy_i[n] && !force_on_i[n] && idle_thresh_i != '0) begin
                            state_q[n]    <= COUNT;
                            idle_cnt_q[n] <= '0;
                        end
                    end
                    COUNT: begin
                        if (busy_i[n] || force_on_i[n] || idle_thresh_i == '0) begin
                            state_q[n] <= RUN;
                        end else if (idle_cnt_q[n] >= thresh_m1_c) begin
                            state_q[n]  <= GATED;
                            clk_en_o[n] <= 1'b0;
                            ready_o[n]  <= 1'b0;
                        end else if (idle_cnt_q[n] != '1) begin
                            idle_cnt_q[n] <= idle_cnt_q[n] + IDLE_W'(1);
                        end
                    end
                    GATED: begin
                        if (busy_i[n] || force_on_i[n]) begin
                            state_q[n]    <= WAKE;
                            wake_cnt_q[n] <= '0;
                            clk_en_o[n]   <= 1'b1;
                        end
                    end
                    WAKE: begin
                        if (wake_cnt_q[n] == WAKE_LAST) begin
                            state_q[n] <= RUN;
                            ready_o[n] <= 1'b1;
                        end else begin
                            wake_cnt_q[n] <= wake_cnt_q[n] + 4'd1;
                        end
                    end
                    default: state_q[n] <= RUN;
                endcase
            end
            n_gated_o <= gated_cnt_c;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cell
        cluster_clock_gating u_cg (
            .clk_i     (clk_i),
            .en_i      (clk_en_o[g]),
            .test_en_i (test_en_i),
            .clk_o     (clk_o[g])
        );
    end

endmodule

// File: doc/cluster_clock_gate_ctrl.md
CLUSTER_CLOCK_GATE_CTRL -- requirements
Module: cluster_clock_gate_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independently gated clock channels (1..32).
REQ-002 SHALL have parameter IDLE_W, default 8, meaning the idle-counter and threshold width in bits.
REQ-003 SHALL have parameter WAKE_CYC, default 2, meaning the wake settling cycles before ready (1..15).
REQ-004 SHALL have port clk_i, input, 1 bit: the free-running clock; the only clock of the block.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port test_en_i, input, 1 bit: scan/test enable, forces all clk_o running.
REQ-007 SHALL have port busy_i, input, NUM_CH bits: per-channel activity/request.
REQ-008 SHALL have port force_on_i, input, NUM_CH bits: per-channel auto-gating inhibit.
REQ-009 SHALL have port idle_thresh_i, input, IDLE_W bits: idle cycles before gating; 0 disables auto-gating.
REQ-010 SHALL have port clk_o, output, NUM_CH bits: gated clocks.
REQ-011 SHALL have port clk_en_o, output, NUM_CH bits: registered gate enables.
REQ-012 SHALL have port ready_o, output, NUM_CH bits: channel clock stable and usable.
REQ-013 SHALL have port n_gated_o, output, $clog2(NUM_CH+1) bits: count of channels in GATED.

Function
REQ-014 SHALL instantiate one cluster_clock_gating cell per channel: clk_i, clk_en_o[n], test_en_i -> clk_o[n].
REQ-015 SHALL run one independent FSM per channel, states RUN, COUNT, GATED, WAKE, each with its own IDLE_W-bit idle counter and 4-bit wake counter.
REQ-016 SHALL drive clk_en_o=1 in RUN, COUNT and WAKE, and clk_en_o=0 in GATED, registered directly from state.
REQ-017 SHALL drive ready_o=1 in RUN and COUNT, and ready_o=0 in GATED and WAKE.
REQ-018 SHALL take RUN->COUNT (idle counter cleared to 0) when busy_i=0, force_on_i=0 and idle_thresh_i!=0; otherwise RUN holds.
REQ-019 SHALL, in COUNT, return to RUN when busy_i=1 or force_on_i=1 (priority over gating); otherwise increment the idle counter, saturating at all-ones.
REQ-020 SHALL take COUNT->GATED when the counter value equals or exceeds idle_thresh_i-1 and busy_i=0 and force_on_i=0; the threshold is compared live every cycle.
REQ-021 SHALL take COUNT->RUN if idle_thresh_i becomes 0 while in COUNT.
REQ-022 SHALL take GATED->WAKE (wake counter cleared) when busy_i=1 or force_on_i=1; otherwise GATED holds.
REQ-023 SHALL, in WAKE, increment the wake counter and go to RUN after exactly WAKE_CYC WAKE cycles; busy_i and force_on_i are ignored during WAKE.
REQ-024 SHALL meet latency: busy_i rises in cycle t while GATED -> clk_en_o=1 at t+1, ready_o=1 at t+1+WAKE_CYC.
REQ-025 SHALL meet latency: busy_i=0 from cycle t in RUN with threshold T>=1 -> clk_en_o=0 at t+1+T.
REQ-026 SHALL NOT let test_en_i alter FSM state or clk_en_o; the cell alone bypasses gating.
REQ-027 SHALL register n_gated_o, updated each cycle to the number of channels in GATED.

Reset
REQ-028 SHALL, while rst_i=1 at a clk_i edge, place every channel in RUN, clear all counters, and drive clk_en_o=all-ones, ready_o=all-ones and n_gated_o=0, so downstream logic receives clocks during reset.
REQ-029 SHALL, on rst_i asserted mid-COUNT/GATED/WAKE, enter RUN at the next edge with no WAKE sequence.

Verification
REQ-030 SHALL cover: T=4, ch0 busy 1->0 at cycle 10 -> ch0 COUNT 11..14, clk_en_o[0]=0 at 15, n_gated_o=1 at 16.
REQ-031 SHALL cover: ch0 GATED, busy_i[0]=1 at cycle 20, WAKE_CYC=2 -> clk_en_o[0]=1 at 21, ready_o[0]=1 at 23.
REQ-032 SHALL cover: busy_i[1] re-asserted in the same cycle the threshold is reached -> ch1 returns to RUN, never gated.
REQ-033 SHALL cover: force_on_i[2]=1 while GATED -> WAKE then RUN; force_on_i held -> never gates; idle_thresh_i=0 -> no channel gates.
REQ-034 SHALL cover: test_en_i=1 with all channels GATED -> clk_o toggles on all channels, clk_en_o stays 0, n_gated_o=NUM_CH.
REQ-035 SHALL cover: rst_i pulsed during WAKE -> next cycle RUN, ready_o=all-ones, n_gated_o=0.
